filter_capture_checker: RTL and testbench
=========================================

Name: filter_capture_checker

Overview:
Synthesizable capture and self-check sink at the output end of the filter sample stream. It receives filter output samples `y` qualified by `ce_out` and discards a programmed number of leading samples to cover pipeline latency. It stores the next N samples in a capture RAM and compares each one against a golden RAM loaded by the host. It reports pass/fail counts, so that the on-chip check matches the file-based golden compare done in simulation.

Parameters:
- DATA_W, 8, sample width of `y` and of both RAMs
- DEPTH, 128, number of entries in the capture RAM and in the golden RAM
- ADDR_W, 7, RAM address width; DEPTH = 2**ADDR_W
- SKIP_W, 8, width of the skip (latency) count

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- start  in  1  one-cycle pulse that arms a capture run
- skip_cnt  in  SKIP_W  number of valid samples to discard before capture; sampled on start
- num_samples  in  ADDR_W+1  number of samples to capture/check; sampled on start
- ce_out  in  1  sample-valid strobe from the filter
- y  in  DATA_W  filter output sample
- gold_we  in  1  golden RAM write enable
- gold_addr  in  ADDR_W  golden RAM write address
- gold_data  in  DATA_W  golden RAM write data
- rd_addr  in  ADDR_W  capture RAM readback address
- rd_data  out  DATA_W  capture RAM data, registered, valid one cycle after rd_addr
- busy  out  1  high in SKIP or CAPTURE
- done  out  1  high in DONE
- pass_cnt  out  ADDR_W+1  matching samples in current/last run
- fail_cnt  out  ADDR_W+1  mismatching samples in current/last run

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=IDLE; busy=0, done=0, pass_cnt=0, fail_cnt=0, rd_data=0.
  - Internal index and skip counters are 0.
  - RAM contents are not cleared.
- A sample is "accepted" on a rising edge where ce_out=1. `y` is ignored when ce_out=0.
- States:
  - IDLE:
    - start=1 latches skip_cnt and min(num_samples, DEPTH), clears pass_cnt, fail_cnt and idx.
    - Next state: DONE if num_samples=0, else SKIP if skip_cnt>0, else CAPTURE.
  - SKIP:
    - Each accepted sample decrements the skip counter.
    - The accepted sample that takes the counter 1->0 is discarded; the next accepted sample is the first captured one.
    - Next state: CAPTURE.
  - CAPTURE:
    - Each accepted sample is written to cap_ram[idx] and compared with gold_ram[idx] (asynchronous read).
    - Equal increments pass_cnt, otherwise fail_cnt; idx then increments.
    - The accepted sample with idx = N-1 is processed, then state goes to DONE.
  - DONE:
    - done=1, counts held.
    - start=1 clears counts and re-arms exactly as from IDLE (no IDLE visit).
- start while busy=1 is ignored; the run is not restarted.
- Latency:
  - busy rises on the edge after start.
  - The counters reflect a sample on the edge that accepts it.
  - done rises on the edge that accepts the last sample.
- Simultaneous gold_we and compare at the same address: the compare uses the pre-write golden value.
- gold_we is accepted in every state. The capture RAM is written only in CAPTURE.
- Readback: rd_data <= cap_ram[rd_addr] every cycle in every state. Read-during-write at the same address returns the old data.
- Saturation: num_samples > DEPTH is clamped to DEPTH, so pass_cnt+fail_cnt never exceeds DEPTH.
- Reset mid-run returns to IDLE immediately; partial counts are lost.

Optional Feature:
- Macro: FIRST_FAIL_EN.
- When defined, two extra outputs are added:
  - first_fail_vld (1 bit): set at the first mismatch of a run; cleared on reset and on an accepted start.
  - first_fail_idx (ADDR_W bits): idx of the first mismatch; it is not updated by later mismatches.
- When not defined, both ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. Golden RAM loaded with 0x00..0x63; start with skip=0, N=100; drive y=0x00..0x63 with ce_out=1 every cycle.
   - Required: done after the 100th sample; pass_cnt=100, fail_cnt=0.
2. Same run, but sample 37 driven as 0xFF.
   - Required: pass_cnt=99, fail_cnt=1.
   - With FIRST_FAIL_EN: first_fail_vld=1, first_fail_idx=37.
3. skip=3, N=4; drive 0xA0,0xA1,0xA2 then 0x10..0x13 with ce_out toggling 1/0; golden = 0x10..0x13.
   - Required: 0xA0..0xA2 discarded; pass_cnt=4; readback of addresses 0..3 returns 0x10..0x13 one cycle after each rd_addr.
4. N=0 -> done on the edge after start with counts 0. N=200 -> run stops after 128 samples with pass_cnt+fail_cnt=128.
5. start pulsed again after 5 samples of a run.
   - Required: ignored.
   - Then rst=0 asserted for 1 cycle mid-run: busy=0, done=0, counts 0, state IDLE; a subsequent start runs normally.
6. In CAPTURE, gold_we to the address being compared in the same cycle with new data equal to y, old data different.
   - Required: fail_cnt increments (old value used); a later rerun of the same sample passes.

Source files
------------

// File: rtl/filter_capture_checker_if.sv
// Bundle of sample-stream, golden-load, readback and status signals for filter_capture_checker.
// FIRST_FAIL_EN adds the first-mismatch report signals.
interface filter_capture_checker_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int SKIP_W = 8
);
    logic              start;
    logic [SKIP_W-1:0] skip_cnt;
    logic [ADDR_W:0]   num_samples;
    logic              ce_out;
    logic [DATA_W-1:0] y;
    logic              gold_we;
    logic [ADDR_W-1:0] gold_addr;
    logic [DATA_W-1:0] gold_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   pass_cnt;
    logic [ADDR_W:0]   fail_cnt;
`ifdef FIRST_FAIL_EN
    logic              first_fail_vld;
    logic [ADDR_W-1:0] first_fail_idx;
`endif

    modport master (
        output start, skip_cnt, num_samples, ce_out, y,
        output gold_we, gold_addr, gold_data, rd_addr,
`ifdef FIRST_FAIL_EN
        input  first_fail_vld, first_fail_idx,
`endif
        input  rd_data, busy, done, pass_cnt, fail_cnt
    );

    modport slave (
        input  start, skip_cnt, num_samples, ce_out, y,
        input  gold_we, gold_addr, gold_data, rd_addr,
`ifdef FIRST_FAIL_EN
        output first_fail_vld, first_fail_idx,
`endif
        output rd_data, busy, done, pass_cnt, fail_cnt
    );
endinterface

// File: rtl/filter_capture_checker.sv
// Capture/self-check sink for the filter output stream: skips latency samples, captures N samples
// and compares them with a host-loaded golden RAM. Optional macro FIRST_FAIL_EN reports the first mismatch.
module filter_capture_checker #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int SKIP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    filter_capture_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    state_t            state, state_next;
    logic [DATA_W-1:0] cap_ram  [DEPTH];
    logic [DATA_W-1:0] gold_ram [DEPTH];
    logic [SKIP_W-1:0] skip_left;
    logic [ADDR_W:0]   n_lat;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   pass_q, fail_q;
    logic [DATA_W-1:0] rd_q;

    logic              arm, skip_fire, cap_fire;
    logic              match, last;
    logic [ADDR_W:0]   n_clamped;

    assign n_clamped = (bus.num_samples > DEPTH_CNT) ? DEPTH_CNT : bus.num_samples;
    // Golden read is asynchronous, so a same-cycle golden write is seen only by later compares.
    assign match     = (bus.y == gold_ram[idx]);
    assign last      = ({1'b0, idx} == n_lat - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        arm        = 1'b0;
        skip_fire  = 1'b0;
        cap_fire   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    arm = 1'b1;
                    if (bus.num_samples == '0)   state_next = DONE;
                    else if (bus.skip_cnt != '0) state_next = SKIP;
                    else                         state_next = CAPTURE;
                end
            end
            SKIP: begin
                if (bus.ce_out) begin
                    skip_fire = 1'b1;
                    if (skip_left == SKIP_W'(1)) state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.ce_out) begin
                    cap_fire = 1'b1;
                    if (last) state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skip_left <= '0;
            n_lat     <= '0;
            idx       <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
        end else if (arm) begin
            skip_left <= bus.skip_cnt;
            n_lat     <= n_clamped;
            idx       <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
        end else begin
            if (skip_fire) skip_left <= skip_left - 1'b1;
            if (cap_fire) begin
                idx <= idx + 1'b1;
                if (match) pass_q <= pass_q + 1'b1;
                else       fail_q <= fail_q + 1'b1;
            end
        end
    end

    // NOTE: the RAM arrays have no reset so they map onto plain memory; only the read register resets.
    always_ff @(posedge clk) begin
        if (bus.gold_we) gold_ram[bus.gold_addr] <= bus.gold_data;
    end

    always_ff @(posedge clk) begin
        if (cap_fire) cap_ram[idx] <= bus.y;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_q <= '0;
        else      rd_q <= cap_ram[bus.rd_addr];
    end

    assign bus.rd_data  = rd_q;
    assign bus.busy     = (state == SKIP) || (state == CAPTURE);
    assign bus.done     = (state == DONE);
    assign bus.pass_cnt = pass_q;
    assign bus.fail_cnt = fail_q;

`ifdef FIRST_FAIL_EN
    logic              ff_vld;
    logic [ADDR_W-1:0] ff_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_vld <= 1'b0;
            ff_idx <= '0;
        end else if (arm) begin
            ff_vld <= 1'b0;
            ff_idx <= '0;
        end else if (cap_fire && !match && !ff_vld) begin
            ff_vld <= 1'b1;
            ff_idx <= idx;
        end
    end

    assign bus.first_fail_vld = ff_vld;
    assign bus.first_fail_idx = ff_idx;
`else
    // First-mismatch tracking is not built.
`endif
endmodule

// File: tb/tb_filter_capture_checker.sv
// Self-checking bench for filter_capture_checker: table-driven runs, hand sequences for
// restart/reset/golden-write corners, and randomized runs against a list-based reference model.
module tb_filter_capture_checker;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int SKIP_W = 8;

    typedef logic [DATA_W-1:0] byte_t;

    typedef struct {
        int skip;
        int n;
        int bad;       // index of the corrupted captured sample, -1 for none
        int gap;       // 0: ce_out every cycle, 1: alternating, 2: random
        int exp_pass;
        int exp_fail;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    filter_capture_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SKIP_W(SKIP_W)) bus ();

    filter_capture_checker #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SKIP_W(SKIP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int    n_vec = 0;
    int    n_err = 0;
    byte_t gold_m [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gold_write(input int a, input byte_t d);
        bus.gold_we   = 1'b1;
        bus.gold_addr = ADDR_W'(a);
        bus.gold_data = d;
        tick();
        bus.gold_we   = 1'b0;
        gold_m[a]     = d;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < DEPTH; i++) gold_write(i, byte_t'(i));
    endtask

    task automatic arm(input int skip, input int n);
        bus.start       = 1'b1;
        bus.skip_cnt    = SKIP_W'(skip);
        bus.num_samples = (ADDR_W+1)'(n);
        bus.ce_out      = 1'b0;
        tick();
        bus.start       = 1'b0;
    endtask

    // Reference: the accepted-sample list minus the skipped head, truncated to DEPTH, compared to gold.
    function automatic void model(input int skip, input int n, input byte_t stim[$],
                                  output int p, output int f, output int ff);
        int nc;
        nc = (n > DEPTH) ? DEPTH : n;
        p  = 0;
        f  = 0;
        ff = -1;
        for (int i = 0; i < nc; i++) begin
            if (stim[skip+i] == gold_m[i]) p++;
            else begin
                f++;
                if (ff < 0) ff = i;
            end
        end
    endfunction

    task automatic run_and_check(input string tag, input int skip, input int n, input byte_t stim[$],
                                 input int gap, input int exp_pass, input int exp_fail);
        int nc, mp, mf, ff;
        nc = (n > DEPTH) ? DEPTH : n;
        model(skip, n, stim, mp, mf, ff);
        arm(skip, n);
        if (nc == 0) begin
            check({tag, "/done_n0"}, bus.done, 1);
            check({tag, "/busy_n0"}, bus.busy, 0);
            check({tag, "/pass_n0"}, bus.pass_cnt, 0);
            check({tag, "/fail_n0"}, bus.fail_cnt, 0);
            return;
        end
        check({tag, "/busy_rise"}, bus.busy, 1);
        for (int k = 0; k < skip + nc; k++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                bus.ce_out = 1'b0;
                bus.y      = byte_t'($urandom);
                tick();
            end
            if (k == skip + nc - 1) check({tag, "/done_early"}, bus.done, 0);
            bus.ce_out = 1'b1;
            bus.y      = stim[k];
            tick();
            if (skip > 0 && k == skip - 1)
                check({tag, "/skip_no_count"}, bus.pass_cnt + bus.fail_cnt, 0);
            if (k == skip && nc > 1)
                check({tag, "/first_count"}, bus.pass_cnt + bus.fail_cnt, 1);
        end
        bus.ce_out = 1'b0;
        check({tag, "/done"}, bus.done, 1);
        check({tag, "/busy_fall"}, bus.busy, 0);
        check({tag, "/pass"}, bus.pass_cnt, exp_pass);
        check({tag, "/fail"}, bus.fail_cnt, exp_fail);
        // Samples after completion must neither count nor land in the capture RAM.
        bus.ce_out = 1'b1;
        bus.y      = ~stim[skip];
        tick();
        tick();
        bus.ce_out = 1'b0;
        check({tag, "/pass_hold"}, bus.pass_cnt, exp_pass);
        check({tag, "/fail_hold"}, bus.fail_cnt, exp_fail);
`ifdef FIRST_FAIL_EN
        check({tag, "/ff_vld"}, bus.first_fail_vld, (ff >= 0) ? 1 : 0);
        if (ff >= 0) check({tag, "/ff_idx"}, bus.first_fail_idx, ff);
`endif
        for (int i = 0; i < nc; i++) begin
            bus.rd_addr = ADDR_W'(i);
            tick();
            check($sformatf("%s/rd%0d", tag, i), bus.rd_data, stim[skip+i]);
        end
    endtask

    vec_t  vecs [7];
    byte_t stim [$];

    initial begin
        int p, f, ff, skip, n, nc;

        vecs[0] = '{skip: 0, n: 100, bad: -1,  gap: 0, exp_pass: 100, exp_fail: 0};
        vecs[1] = '{skip: 0, n: 100, bad: 37,  gap: 0, exp_pass: 99,  exp_fail: 1};
        vecs[2] = '{skip: 3, n: 4,   bad: -1,  gap: 1, exp_pass: 4,   exp_fail: 0};
        vecs[3] = '{skip: 0, n: 0,   bad: -1,  gap: 0, exp_pass: 0,   exp_fail: 0};
        vecs[4] = '{skip: 0, n: 200, bad: -1,  gap: 0, exp_pass: 128, exp_fail: 0};
        vecs[5] = '{skip: 2, n: 128, bad: 127, gap: 2, exp_pass: 127, exp_fail: 1};
        vecs[6] = '{skip: 1, n: 1,   bad: 0,   gap: 0, exp_pass: 0,   exp_fail: 1};

        bus.start = 1'b0; bus.skip_cnt = '0; bus.num_samples = '0;
        bus.ce_out = 1'b0; bus.y = '0;
        bus.gold_we = 1'b0; bus.gold_addr = '0; bus.gold_data = '0; bus.rd_addr = '0;

        // Reset state
        repeat (3) tick();
        check("rst/busy", bus.busy, 0);
        check("rst/done", bus.done, 0);
        check("rst/pass", bus.pass_cnt, 0);
        check("rst/fail", bus.fail_cnt, 0);
        check("rst/rd_data", bus.rd_data, 0);
        rst = 1'b1;
        tick();
        check("idle/busy", bus.busy, 0);

        // Table-driven runs over a ramp golden image
        load_ramp();
        for (int v = 0; v < 7; v++) begin
            nc = (vecs[v].n > DEPTH) ? DEPTH : vecs[v].n;
            stim = {};
            for (int k = 0; k < vecs[v].skip; k++) stim.push_back(byte_t'(8'hA0 + k));
            for (int i = 0; i < nc; i++) stim.push_back((i == vecs[v].bad) ? 8'hFF : byte_t'(i));
            run_and_check($sformatf("vec%0d", v), vecs[v].skip, vecs[v].n, stim, vecs[v].gap,
                          vecs[v].exp_pass, vecs[v].exp_fail);
        end

        // Skip of three leading samples with toggling ce_out and a distinct golden image
        for (int i = 0; i < 4; i++) gold_write(i, byte_t'(8'h10 + i));
        stim = '{8'hA0, 8'hA1, 8'hA2, 8'h10, 8'h11, 8'h12, 8'h13};
        run_and_check("skip3", 3, 4, stim, 1, 4, 0);

        // Start during a run is ignored; reset mid-run clears everything
        load_ramp();
        arm(0, 50);
        for (int i = 0; i < 5; i++) begin
            bus.ce_out = 1'b1; bus.y = byte_t'(i); tick();
        end
        bus.ce_out = 1'b0;
        bus.start = 1'b1; bus.num_samples = 8'd2; bus.skip_cnt = 8'd9;
        tick();
        bus.start = 1'b0;
        check("restart/busy", bus.busy, 1);
        check("restart/pass", bus.pass_cnt, 5);
        for (int i = 5; i < 7; i++) begin
            bus.ce_out = 1'b1; bus.y = byte_t'(i); tick();
        end
        bus.ce_out = 1'b0;
        check("restart/pass7", bus.pass_cnt, 7);
        check("restart/not_done", bus.done, 0);
        rst = 1'b0;
        #2;
        check("midrst/busy", bus.busy, 0);
        check("midrst/done", bus.done, 0);
        check("midrst/pass", bus.pass_cnt, 0);
        check("midrst/fail", bus.fail_cnt, 0);
        tick();
        rst = 1'b1;
        tick();
        stim = '{8'h00, 8'h01, 8'h02};
        run_and_check("after_rst", 0, 3, stim, 0, 3, 0);

        // Golden write to the compared address in the same cycle: old golden value is used
        gold_write(0, 8'h55);
        bus.rd_addr = '0;
        arm(0, 1);
        bus.ce_out = 1'b1; bus.y = 8'hAA;
        bus.gold_we = 1'b1; bus.gold_addr = '0; bus.gold_data = 8'hAA;
        tick();
        bus.ce_out = 1'b0; bus.gold_we = 1'b0;
        gold_m[0] = 8'hAA;
        check("gwr/fail", bus.fail_cnt, 1);
        check("gwr/pass", bus.pass_cnt, 0);
        check("gwr/done", bus.done, 1);
        check("gwr/rd_old", bus.rd_data, 8'h00);
        tick();
        check("gwr/rd_new", bus.rd_data, 8'hAA);
`ifdef FIRST_FAIL_EN
        check("gwr/ff_vld", bus.first_fail_vld, 1);
        check("gwr/ff_idx", bus.first_fail_idx, 0);
`endif
        stim = '{8'hAA};
        run_and_check("gwr_rerun", 0, 1, stim, 0, 1, 0);

        // Randomized runs against the reference model
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < DEPTH; i++) gold_write(i, byte_t'($urandom));
            skip = $urandom_range(0, 4);
            n    = $urandom_range(1, 140);
            nc   = (n > DEPTH) ? DEPTH : n;
            stim = {};
            for (int k = 0; k < skip; k++) stim.push_back(byte_t'($urandom));
            for (int i = 0; i < nc; i++)
                stim.push_back(($urandom_range(0, 3) != 0) ? gold_m[i] : byte_t'($urandom));
            model(skip, n, stim, p, f, ff);
            run_and_check($sformatf("rand%0d", r), skip, n, stim, 2, p, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
